leaf_egress_resend_buffer: RTL
==============================

LEAF_EGRESS_RESEND_BUFFER -- requirements
Module: leaf_egress_resend_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..64).
REQ-002 SHALL have port clk_400 (input, 1 bit): the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_400 (input, 1 bit): reset, synchronous and active-high.
REQ-004 SHALL have port din_leaf_interface2bft (input, 49 bits): packet from the page; bit 48 = valid, bits 47:0 = payload.
REQ-005 SHALL have port in_full (output, 1 bit): FIFO holds DEPTH entries; the page must not present a valid packet.
REQ-006 SHALL have port dout_leaf_interface2bft (output, 49 bits): packet to the BFT leaf; bit 48 = valid.
REQ-007 SHALL have port resend (input, 1 bit): BFT rejection of the packet driven in the previous cycle.
REQ-008 SHALL have port overflow (output, 1 bit): sticky flag; a valid packet arrived while in_full was high.

Function
REQ-009 SHALL push din[47:0] into the FIFO in any cycle where din[48]=1 and count<DEPTH.
REQ-010 SHALL discard din when din[48]=1 and count==DEPTH, even if a pop occurs in the same cycle, and SHALL set overflow.
REQ-011 SHALL drive in_full as a registered output equal to (count==DEPTH), updated the cycle after count changes.
REQ-012 SHALL implement FSM {IDLE, WAIT}; reset state IDLE.
REQ-013 SHALL, in IDLE with FIFO non-empty, drive dout={1'b1, head} for exactly one cycle and go to WAIT; in IDLE with FIFO empty, stay in IDLE.
REQ-014 SHALL, in WAIT, drive dout=49'b0 and sample resend: resend=1 -> keep head, go to IDLE; resend=0 -> pop head, go to IDLE.
REQ-015 SHALL ignore resend in IDLE.
REQ-016 SHALL register dout; a head written into an empty FIFO appears on dout no earlier than 2 cycles after the din write cycle.
REQ-017 SHALL sustain at most one packet per 2 cycles; order of delivered packets SHALL equal push order, with no duplicates accepted by the BFT.
REQ-018 SHALL allow a simultaneous push and pop when count<DEPTH, leaving count unchanged.
REQ-019 SHALL wrap read and write pointers modulo DEPTH, with count width clog2(DEPTH)+1.

Reset
REQ-020 SHALL, while reset_400=1, force count=0, both pointers=0, FSM=IDLE, dout=0, in_full=0, overflow=0, and the statistics counters to 0.
REQ-021 SHALL discard FIFO contents and any packet awaiting resend when reset_400 asserts mid-operation; no packet SHALL be emitted in the cycle after reset deasserts.
REQ-022 SHALL clear overflow only by reset.

Configuration
REQ-023 SHALL, with macro LEAF_EGRESS_STATS_EN defined, add outputs sent_cnt (32 bits: packets popped per REQ-014) and resend_cnt (32 bits: WAIT cycles with resend=1), both wrapping at 2^32.
REQ-024 SHALL, without LEAF_EGRESS_STATS_EN, omit those ports and the counter logic entirely; all other behaviour SHALL be identical.

Verification
REQ-025 Single packet: din=0x1_0000_0000_00AB for 1 cycle, resend=0 -> dout=0x1_0000_0000_00AB for exactly 1 cycle, 2 cycles later; FIFO empty afterwards.
REQ-026 Retry: same packet, resend=1 in its first two WAIT cycles, then 0 -> packet emitted 3 times, 2 cycles apart; popped once; resend_cnt=2 and sent_cnt=1 when STATS_EN is defined.
REQ-027 Fill: 16 back-to-back packets while resend=1 is held continuously -> in_full=1 after the 16th; a 17th valid packet sets overflow=1, and that packet is never emitted.
REQ-028 Order/drain: 16 packets 0..15 pushed, resend=0 -> dout carries 0..15 in order, one every 2 cycles; in_full falls 1 cycle after the first pop.
REQ-029 Reset mid-stream: reset_400=1 for 1 cycle while in WAIT with 5 entries queued -> dout=0, in_full=0, overflow=0; no output until a new push.

Source files
------------

// File: rtl/leaf_egress_resend_buffer.sv
// Egress FIFO with single-outstanding resend handshake toward the BFT leaf.
// Define LEAF_EGRESS_STATS_EN to add the sent_cnt/resend_cnt statistics outputs.
module leaf_egress_resend_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk_400,
  input  logic        reset_400,
  input  logic [48:0] din_leaf_interface2bft,
  input  logic        resend,
  output logic        in_full,
  output logic [48:0] dout_leaf_interface2bft,
  output logic        overflow
`ifdef LEAF_EGRESS_STATS_EN
  ,
  output logic [31:0] sent_cnt,
  output logic [31:0] resend_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [48:0]     dout_q, dout_d;
  logic            in_full_q;
  logic            overflow_q, overflow_d;
  logic [47:0]     mem_q [DEPTH];

  logic            push;
  logic            drop;
  logic            pop;

  // A full FIFO drops the incoming packet even when a pop frees a slot this cycle.
  always_comb begin
    push = din_leaf_interface2bft[48] && (count_q != FULL_CNT);
    drop = din_leaf_interface2bft[48] && (count_q == FULL_CNT);
    pop  = (state_q == WAIT) && !resend;
  end

  always_comb begin
    state_d = state_q;
    dout_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          dout_d  = {1'b1, mem_q[rd_ptr_q]};
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_400) begin
    if (reset_400) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      in_full_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      in_full_q  <= (count_d == FULL_CNT);
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_400) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din_leaf_interface2bft[47:0];
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign in_full                 = in_full_q;
  assign overflow                = overflow_q;

`ifdef LEAF_EGRESS_STATS_EN
  logic [31:0] sent_cnt_q;
  logic [31:0] resend_cnt_q;

  always_ff @(posedge clk_400) begin
    if (reset_400) begin
      sent_cnt_q   <= '0;
      resend_cnt_q <= '0;
    end else begin
      if (pop) begin
        sent_cnt_q <= sent_cnt_q + 32'd1;
      end
      if ((state_q == WAIT) && resend) begin
        resend_cnt_q <= resend_cnt_q + 32'd1;
      end
    end
  end

  assign sent_cnt   = sent_cnt_q;
  assign resend_cnt = resend_cnt_q;
`endif

endmodule
